// File: rtl/wdt_window_ctrl.sv
// -----------------------------------------------------------------------------
// wdt_window_ctrl
// Windowed watchdog controller. Software programs timeout (T), service window
// (W) and early-warning lead (P) while idle, arms the watchdog with start, and
// must then service it with keyed kicks inside the window. Expiry or a bad
// kick raises a reset request stretched over RST_HOLD cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cfg_we       config write strobe (accepted only in IDLE and only if legal)
//   cfg_timeout  timeout T in cycles
//   cfg_window   window W: kicks accepted only when cnt >= W
//   cfg_warn     warning lead P (0 disables irq_warn)
//   start        arm pulse
//   kick         service pulse
//   kick_key     key qualifying a kick
//   rst_o        reset request to the reset generator
//   irq_warn     early-warning interrupt, level
//   running      high while armed; configuration is locked
//   cfg_err      one-cycle pulse for a rejected config write
//   cause        last reset cause: 00 none, 01 timeout, 10 early kick, 11 bad key
// -----------------------------------------------------------------------------
module wdt_window_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEF_TIMEOUT = 100,
  parameter logic [7:0]  KEY         = 8'hA5,
  parameter int unsigned RST_HOLD    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_warn,
  input  logic             start,
  input  logic             kick,
  input  logic [7:0]       kick_key,
  output logic             rst_o,
  output logic             irq_warn,
  output logic             running,
  output logic             cfg_err,
  output logic [1:0]       cause
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_TWO   = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0]  T_RESET   = CNT_W'(DEF_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_TMO   = 2'b01;
  localparam logic [1:0] CAUSE_EARLY = 2'b10;
  localparam logic [1:0] CAUSE_KEY   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_r,    state_nxt_s;
  logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
  logic [CNT_W-1:0]  t_r,        t_nxt_s;
  logic [CNT_W-1:0]  w_r,        w_nxt_s;
  logic [CNT_W-1:0]  p_r,        p_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic              rst_o_r,    rst_o_nxt_s;
  logic              irq_warn_r, irq_warn_nxt_s;
  logic              running_r,  running_nxt_s;
  logic              cfg_err_r,  cfg_err_nxt_s;
  logic [1:0]        cause_r,    cause_nxt_s;

  logic cfg_legal_s;
  logic key_ok_s;
  logic in_window_s;
  logic expire_s;
  logic warn_hit_s;

  // Qualifiers shared by the state logic; all compares are unsigned CNT_W-bit.
  always_comb begin
    cfg_legal_s = (cfg_timeout >= CNT_TWO) && (cfg_window < cfg_timeout) &&
                  (cfg_warn < cfg_timeout);
    key_ok_s    = (kick_key == KEY);
    in_window_s = (cnt_r >= w_r);
    expire_s    = (cnt_r == (t_r - CNT_ONE));
    warn_hit_s  = (p_r != CNT_ZERO) && (cnt_r >= (t_r - p_r));
  end

  // Next-state and next-output logic for the IDLE/RUN/HOLD controller.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    t_nxt_s        = t_r;
    w_nxt_s        = w_r;
    p_nxt_s        = p_r;
    hold_cnt_nxt_s = hold_cnt_r;
    rst_o_nxt_s    = rst_o_r;
    irq_warn_nxt_s = irq_warn_r;
    running_nxt_s  = running_r;
    cfg_err_nxt_s  = 1'b0;
    cause_nxt_s    = cause_r;

    case (state_r)
      IDLE: begin
        // A legal write in the start cycle is applied first, so the run
        // that starts on this edge already uses the new values.
        if (cfg_we) begin
          if (cfg_legal_s) begin
            t_nxt_s = cfg_timeout;
            w_nxt_s = cfg_window;
            p_nxt_s = cfg_warn;
          end else begin
            cfg_err_nxt_s = 1'b1;
          end
        end else begin
          cfg_err_nxt_s = 1'b0;
        end
        if (start) begin
          state_nxt_s    = RUN;
          cnt_nxt_s      = CNT_ZERO;
          running_nxt_s  = 1'b1;
          irq_warn_nxt_s = 1'b0;
          cause_nxt_s    = CAUSE_NONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      RUN: begin
        cfg_err_nxt_s = cfg_we;
        cnt_nxt_s     = cnt_r + CNT_ONE;
        // Kick faults take priority, then a valid kick (which also beats
        // expiry in the same cycle), then expiry, then the warning.
        if (kick && !key_ok_s) begin
          state_nxt_s = HOLD;
          cause_nxt_s = CAUSE_KEY;
        end else if (kick && !in_window_s) begin
          state_nxt_s = HOLD;
          cause_nxt_s = CAUSE_EARLY;
        end else if (kick) begin
          cnt_nxt_s      = CNT_ZERO;
          irq_warn_nxt_s = 1'b0;
        end else if (expire_s) begin
          state_nxt_s = HOLD;
          cause_nxt_s = CAUSE_TMO;
        end else if (warn_hit_s) begin
          irq_warn_nxt_s = 1'b1;
        end else begin
          irq_warn_nxt_s = irq_warn_r;
        end
        if (state_nxt_s == HOLD) begin
          cnt_nxt_s      = CNT_ZERO;
          hold_cnt_nxt_s = HOLD_ZERO;
          rst_o_nxt_s    = 1'b1;
          irq_warn_nxt_s = 1'b0;
          running_nxt_s  = 1'b0;
        end else begin
          running_nxt_s = 1'b1;
        end
      end

      HOLD: begin
        cfg_err_nxt_s = cfg_we;
        // rst_o rose on the entry edge, so it is dropped once the counter
        // has seen RST_HOLD-1 further cycles.
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s    = IDLE;
          rst_o_nxt_s    = 1'b0;
          hold_cnt_nxt_s = HOLD_ZERO;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
        end
      end

      default: begin
        state_nxt_s    = IDLE;
        cnt_nxt_s      = CNT_ZERO;
        hold_cnt_nxt_s = HOLD_ZERO;
        rst_o_nxt_s    = 1'b0;
        irq_warn_nxt_s = 1'b0;
        running_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      t_r        <= T_RESET;
      w_r        <= CNT_ZERO;
      p_r        <= CNT_ZERO;
      hold_cnt_r <= HOLD_ZERO;
      rst_o_r    <= 1'b0;
      irq_warn_r <= 1'b0;
      running_r  <= 1'b0;
      cfg_err_r  <= 1'b0;
      cause_r    <= CAUSE_NONE;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      t_r        <= t_nxt_s;
      w_r        <= w_nxt_s;
      p_r        <= p_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      rst_o_r    <= rst_o_nxt_s;
      irq_warn_r <= irq_warn_nxt_s;
      running_r  <= running_nxt_s;
      cfg_err_r  <= cfg_err_nxt_s;
      cause_r    <= cause_nxt_s;
    end
  end

  assign rst_o    = rst_o_r;
  assign irq_warn = irq_warn_r;
  assign running  = running_r;
  assign cfg_err  = cfg_err_r;
  assign cause    = cause_r;

endmodule
